// File: rtl/stage_if.sv
// stage_if: instruction fetch stage with a one-word skid register and redirect kill tracking.
// Optional feature macro IF_ALIGN_CHECK_EN: a misaligned pc raises EC_ADEL instead of fetching.

`ifndef IF2ID_WIRE_WIDTH
`define IF2ID_WIRE_WIDTH 68
`endif
`ifndef EC_NONE
`define EC_NONE 4'h0
`endif
`ifndef EC_ADEL
`define EC_ADEL 4'h4
`endif

module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          clear,
    input  logic                          branch_valid,
    input  logic [31:0]                   branch_target,
    output logic                          mem_req,
    output logic [31:0]                   mem_addr,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic [`IF2ID_WIRE_WIDTH-1:0]  interstage_if2id
);

    localparam int unsigned W   = `IF2ID_WIRE_WIDTH;
    localparam int unsigned EcW = W - 64;

    // if2id layout: {instr[31:0], next_pc[31:0], exc_code}
    localparam logic [W-1:0] Bubble = {32'h0, 32'h0, `EC_NONE};

`ifdef IF_ALIGN_CHECK_EN
    localparam bit AlignCheck = 1'b1;
`else
    localparam bit AlignCheck = 1'b0;
`endif

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold
    } state_e;

    state_e       st_q, st_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  kill_addr_q, kill_addr_d;
    logic [W-1:0] skid_q, skid_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] out_q, out_d;

    logic [31:0]  fetch_addr;
    logic [31:0]  pc_inc;
    logic         misaligned;
    logic [W-1:0] word_pkt;
    logic [W-1:0] fault_pkt;

    function automatic logic [W-1:0] pack(input logic [31:0] instr, input logic [31:0] npc,
                                          input logic [EcW-1:0] ec);
        return {instr, npc, ec};
    endfunction

    always_comb begin
        fetch_addr = AlignCheck ? pc_q : {pc_q[31:2], 2'b00};
        pc_inc     = fetch_addr + 32'd4;
        misaligned = AlignCheck && (pc_q[1:0] != 2'b00);
        word_pkt   = pack(mem_rdata, pc_inc, `EC_NONE);
        fault_pkt  = pack(32'h0, pc_inc, `EC_ADEL);

        // A killed request must stay presented until memory acks it.
        mem_req  = rst && (st_q != StHold) && (kill_q || !misaligned);
        mem_addr = kill_q ? kill_addr_q : fetch_addr;

        interstage_if2id = out_q;
    end

    always_comb begin
        st_d        = st_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        kill_addr_d = kill_addr_q;
        skid_d      = skid_q;
        skid_vld_d  = skid_vld_q;
        out_d       = out_q;

        if (branch_valid) begin
            pc_d        = branch_target;
            st_d        = StFetch;
            skid_vld_d  = 1'b0;
            kill_d      = mem_req && !mem_ack;
            kill_addr_d = mem_addr;
            if (clear || !stall) begin
                out_d = Bubble;
            end
        end else if (kill_q) begin
            st_d = StFetch;
            if (mem_ack) begin
                kill_d = 1'b0;
            end
            if (clear || !stall) begin
                out_d = Bubble;
            end
        end else begin
            unique case (st_q)
                StFetch, StWait: begin
                    if (misaligned) begin
                        if (clear) begin
                            out_d = Bubble;
                            st_d  = StFetch;
                        end else if (stall) begin
                            skid_d     = fault_pkt;
                            skid_vld_d = 1'b1;
                            st_d       = StHold;
                        end else begin
                            out_d      = fault_pkt;
                            skid_vld_d = 1'b0;
                            st_d       = StHold;
                        end
                    end else if (mem_ack) begin
                        // A cleared word is dropped and refetched from the same pc.
                        if (clear) begin
                            out_d = Bubble;
                            st_d  = StFetch;
                        end else if (stall) begin
                            skid_d     = word_pkt;
                            skid_vld_d = 1'b1;
                            st_d       = StHold;
                        end else begin
                            out_d = word_pkt;
                            pc_d  = pc_inc;
                            st_d  = StFetch;
                        end
                    end else begin
                        st_d = StWait;
                        if (clear || !stall) begin
                            out_d = Bubble;
                        end
                    end
                end
                StHold: begin
                    if (clear) begin
                        out_d      = Bubble;
                        skid_vld_d = 1'b0;
                        st_d       = misaligned ? StHold : StFetch;
                    end else if (!stall) begin
                        out_d      = skid_vld_q ? skid_q : Bubble;
                        skid_vld_d = 1'b0;
                        if (!misaligned) begin
                            pc_d = pc_inc;
                            st_d = StFetch;
                        end
                    end
                end
                default: begin
                    st_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= StFetch;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            kill_addr_q <= 32'h0;
            skid_q      <= Bubble;
            skid_vld_q  <= 1'b0;
            out_q       <= Bubble;
        end else begin
            st_q        <= st_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            kill_addr_q <= kill_addr_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed-vector bench for stage_if with a combinational memory model
// returning addr ^ 32'hA5A5_0000 whenever ack is enabled.

`ifndef IF2ID_WIRE_WIDTH
`define IF2ID_WIRE_WIDTH 68
`endif
`ifndef EC_NONE
`define EC_NONE 4'h0
`endif
`ifndef EC_ADEL
`define EC_ADEL 4'h4
`endif

module tb_stage_if;

    localparam int unsigned W = `IF2ID_WIRE_WIDTH;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         clear;
    logic         branch_valid;
    logic [31:0]  branch_target;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [W-1:0] if2id;
    logic         ack_en;

    int checks = 0;
    int errors = 0;

    stage_if #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .clear            (clear),
        .branch_valid     (branch_valid),
        .branch_target    (branch_target),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .interstage_if2id (if2id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_ack   = ack_en & mem_req;
        mem_rdata = mem_addr ^ 32'hA5A5_0000;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pkt(input logic [31:0] instr, input logic [31:0] npc,
                                         input logic [3:0] ec);
        return {instr, npc, ec};
    endfunction

    function automatic logic [W-1:0] word_at(input logic [31:0] a);
        return pkt(a ^ 32'hA5A5_0000, a + 32'd4, `EC_NONE);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] bubble;
        bubble        = pkt(32'h0, 32'h0, `EC_NONE);
        rst           = 1'b0;
        stall         = 1'b0;
        clear         = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        ack_en        = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_req", W'(mem_req), W'(1'b0));
        check("rst_out", if2id, bubble);
        check("rst_addr", W'(mem_addr), W'(32'h0));

        // Zero-wait stream: 0, 4
        rst = 1'b1;
        #1;
        check("first_req", W'(mem_req), W'(1'b1));
        check("first_addr", W'(mem_addr), W'(32'h0));
        tick();
        check("out_0", if2id, word_at(32'h0));
        check("addr_4", W'(mem_addr), W'(32'h4));
        tick();
        check("out_4", if2id, word_at(32'h4));

        // Three-cycle ack delay at 8
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_addr8", W'(mem_addr), W'(32'h8));
            check("wait_req", W'(mem_req), W'(1'b1));
            check("wait_out", if2id, bubble);
        end
        ack_en = 1'b1;
        tick();
        check("out_8", if2id, word_at(32'h8));
        check("addr_12", W'(mem_addr), W'(32'hC));

        // Stall for four cycles while word 12 is acked
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_out", if2id, word_at(32'h8));
            check("stall_req", W'(mem_req), W'(1'b0));
        end
        stall = 1'b0;
        tick();
        check("out_12", if2id, word_at(32'hC));
        check("addr_16", W'(mem_addr), W'(32'h10));

        // Redirect to 0x100 while waiting at 16
        ack_en = 1'b0;
        tick();
        check("wait16_addr", W'(mem_addr), W'(32'h10));
        branch_valid  = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_valid = 1'b0;
        check("kill_addr", W'(mem_addr), W'(32'h10));
        check("kill_req", W'(mem_req), W'(1'b1));
        tick();
        check("kill_addr2", W'(mem_addr), W'(32'h10));
        ack_en = 1'b1;
        tick();
        check("stale_drop", if2id, bubble);
        check("addr_100", W'(mem_addr), W'(32'h100));
        tick();
        check("out_100", if2id, word_at(32'h100));

        // Stall captures 0x104, then clear+stall flushes it
        stall = 1'b1;
        tick();
        check("hold_out", if2id, word_at(32'h100));
        check("hold_req", W'(mem_req), W'(1'b0));
        clear = 1'b1;
        tick();
        check("clear_out", if2id, bubble);
        check("clear_refetch", W'(mem_addr), W'(32'h104));
        check("clear_req", W'(mem_req), W'(1'b1));
        clear = 1'b0;
        stall = 1'b0;
        tick();
        check("out_104", if2id, word_at(32'h104));

        // Redirect with same-cycle ack, then next_pc wrap
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_valid = 1'b0;
        check("br_drop", if2id, bubble);
        check("addr_fffc", W'(mem_addr), W'(32'hFFFF_FFFC));
        tick();
        check("out_wrap", if2id, pkt(32'hFFFF_FFFC ^ 32'hA5A5_0000, 32'h0, `EC_NONE));
        check("addr_wrap", W'(mem_addr), W'(32'h0));

        // Misaligned redirect target
        branch_valid  = 1'b1;
        branch_target = 32'h102;
        tick();
        branch_valid = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        check("adel_req", W'(mem_req), W'(1'b0));
        tick();
        check("adel_out", if2id, pkt(32'h0, 32'h106, `EC_ADEL));
        tick();
        check("adel_hold", W'(mem_req), W'(1'b0));
`else
        check("unal_req", W'(mem_req), W'(1'b1));
        check("unal_addr", W'(mem_addr), W'(32'h100));
        tick();
        check("unal_out", if2id, word_at(32'h100));
`endif

        // Asynchronous reset mid-fetch
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_req", W'(mem_req), W'(1'b0));
        check("arst_out", if2id, bubble);
        check("arst_addr", W'(mem_addr), W'(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
